// File: rtl/pll_lock_supervisor.sv
// PLL bring-up/recovery sequencer: pulses PLL reset, waits for lock with bounded
// retries, qualifies lock stability, then releases the system reset.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int RTY_W     = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [RTY_W-1:0] retries_r;
  logic [RTY_W-1:0] retries_nxt_s;
  logic             enter_s;
  logic             loss_inc_s;
  logic             lock_meta_r;
  logic             lock_sync_r;
  logic             locked_s;

  assign locked_s = lock_sync_r;
  assign state    = state_r;

  // Two-stage synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state, counter and retry decisions; relock_req overrides everything.
  always_comb begin
    state_nxt_s   = state_r;
    retries_nxt_s = retries_r;
    enter_s       = 1'b0;
    loss_inc_s    = 1'b0;
    if (relock_req) begin
      state_nxt_s   = S_RESET_PLL;
      retries_nxt_s = '0;
      enter_s       = 1'b1;
    end else begin
      case (state_r)
        S_RESET_PLL: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = S_WAIT_LOCK;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = S_RESET_PLL;
          end
        end
        S_WAIT_LOCK: begin
          // Lock wins over a coincident timeout.
          if (locked_s) begin
            state_nxt_s = S_STABILIZE;
            enter_s     = 1'b1;
          end else if (cnt_r == TMO_LAST) begin
            retries_nxt_s = retries_r + RTY_ONE;
            enter_s       = 1'b1;
            if (retries_nxt_s == RTY_MAX) begin
              state_nxt_s = S_FAIL;
            end else begin
              state_nxt_s = S_RESET_PLL;
            end
          end else begin
            state_nxt_s = S_WAIT_LOCK;
          end
        end
        S_STABILIZE: begin
          if (!locked_s) begin
            state_nxt_s = S_WAIT_LOCK;
            enter_s     = 1'b1;
          end else if (cnt_r == STB_LAST) begin
            state_nxt_s   = S_RUN;
            retries_nxt_s = '0;
            enter_s       = 1'b1;
          end else begin
            state_nxt_s = S_STABILIZE;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nxt_s = S_RESET_PLL;
            loss_inc_s  = 1'b1;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_FAIL: begin
          state_nxt_s = S_FAIL;
        end
        default: begin
          state_nxt_s   = S_RESET_PLL;
          retries_nxt_s = '0;
          enter_s       = 1'b1;
        end
      endcase
    end

    cnt_nxt_s = cnt_r;
    if (enter_s) begin
      cnt_nxt_s = '0;
    end else if ((state_r == S_RESET_PLL) || (state_r == S_WAIT_LOCK) ||
                 (state_r == S_STABILIZE)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State register plus outputs decoded from the next state so they are flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_RESET_PLL;
      cnt_r      <= '0;
      retries_r  <= '0;
      loss_count <= 8'd0;
      pll_rst    <= 1'b1;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      retries_r  <= retries_nxt_s;
      if (loss_inc_s && (loss_count != 8'd255)) begin
        loss_count <= loss_count + 8'd1;
      end else begin
        loss_count <= loss_count;
      end
      pll_rst    <= (state_nxt_s == S_RESET_PLL) || (state_nxt_s == S_FAIL);
      sys_reset  <= (state_nxt_s != S_RUN);
      ready      <= (state_nxt_s == S_RUN);
      fail       <= (state_nxt_s == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: expected timelines are derived
// arithmetically from the sequencing rules, with randomized lock/glitch timing.
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 3;
  localparam int ROUND = RC + LT;           // one reset+wait attempt
  localparam int FAIL_AT = ROUND * MR;      // first FAIL cycle when never locked
  localparam int RUN_AT = RC + 1 + SC;      // first RUN cycle on clean bring-up

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [2:0] state;
  logic [7:0] loss_count;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clock(clock), .reset(reset), .locked(locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .fail(fail),
    .state(state), .loss_count(loss_count)
  );

  always #5 clock = ~clock;

  // {pll_rst, sys_reset, ready, fail} implied by a state number
  function automatic logic [3:0] outs_of(input int st);
    logic [3:0] r;
    r[3] = (st == 0) || (st == 4);
    r[2] = (st != 3);
    r[1] = (st == 3);
    r[0] = (st == 4);
    return r;
  endfunction

  // State when locked stays low forever
  function automatic int exp_nolock(input int n);
    if (n >= FAIL_AT) return 4;
    return ((n % ROUND) < RC) ? 0 : 1;
  endfunction

  // State when locked rises (and stays) at cycle a, low before
  function automatic int exp_arrival(input int n, input int a);
    int c;
    int t;
    c = a + 2;
    t = -1;
    for (int r = 0; r < MR; r++) begin
      if ((t < 0) && (c <= ROUND * r + ROUND - 1)) begin
        t = (c < ROUND * r + RC) ? (ROUND * r + RC) : c;
      end
    end
    if ((t < 0) || (n <= t)) return exp_nolock(n);
    if (n <= t + SC) return 2;
    return 3;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic lk);
    reset = 1'b1;
    relock_req = 1'b0;
    locked = lk;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    relock_req = 1'b0;
    locked = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({state, pll_rst, sys_reset, ready, fail, loss_count} !== {3'd0, 4'b1100, 8'd0}) begin
      n_err++;
      $display("FAIL reset_hold got st=%0d outs=%b loss=%0d exp st=0 outs=1100 loss=0",
               state, {pll_rst, sys_reset, ready, fail}, loss_count);
    end
    reset = 1'b0;
    n_cmp++;
    if ({state, pll_rst, sys_reset, ready, fail, loss_count} !== {3'd0, 4'b1100, 8'd0}) begin
      n_err++;
      $display("FAIL reset_cycle0 got st=%0d outs=%b loss=%0d exp st=0 outs=1100 loss=0",
               state, {pll_rst, sys_reset, ready, fail}, loss_count);
    end
  endtask

  task automatic test_bringup();
    int e;
    do_reset(1'b1);
    for (int n = 0; n <= RUN_AT + 6; n++) begin
      e = (n < RC) ? 0 : (n == RC) ? 1 : (n < RUN_AT) ? 2 : 3;
      n_cmp++;
      if ({state, pll_rst, sys_reset, ready, fail} !== {3'(e), outs_of(e)}) begin
        n_err++;
        $display("FAIL bringup cyc=%0d got st=%0d outs=%b exp st=%0d outs=%b",
                 n, state, {pll_rst, sys_reset, ready, fail}, e, outs_of(e));
      end
      step();
    end
  endtask

  task automatic test_never_lock();
    int e;
    do_reset(1'b0);
    for (int n = 0; n <= FAIL_AT + 210; n++) begin
      e = exp_nolock(n);
      n_cmp++;
      if ({state, pll_rst, sys_reset, ready, fail} !== {3'(e), outs_of(e)}) begin
        n_err++;
        $display("FAIL never_lock cyc=%0d got st=%0d outs=%b exp st=%0d outs=%b",
                 n, state, {pll_rst, sys_reset, ready, fail}, e, outs_of(e));
      end
      step();
    end
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    n_cmp++;
    if ({state, pll_rst, fail} !== {3'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL fail_relock got st=%0d pll_rst=%b fail=%b exp st=0 pll_rst=1 fail=0",
               state, pll_rst, fail);
    end
  endtask

  task automatic test_lock_arrival();
    int a;
    int e;
    for (int it = 0; it < 8; it++) begin
      a = (it == 0) ? 33 : (it == 1) ? 105 : (it == 2) ? 106 : int'($urandom_range(115, 0));
      do_reset(1'b0);
      for (int n = 0; n <= 140; n++) begin
        if (n == a) locked = 1'b1;
        e = exp_arrival(n, a);
        n_cmp++;
        if ({state, pll_rst, sys_reset, ready, fail} !== {3'(e), outs_of(e)}) begin
          n_err++;
          $display("FAIL lock_arrival a=%0d cyc=%0d got st=%0d outs=%b exp st=%0d outs=%b",
                   a, n, state, {pll_rst, sys_reset, ready, fail}, e, outs_of(e));
        end
        step();
      end
    end
  endtask

  task automatic test_glitch();
    int g;
    int e;
    for (int it = 0; it < 6; it++) begin
      g = (it == 0) ? 10 : (it == 1) ? 3 : int'($urandom_range(10, 3));
      do_reset(1'b1);
      for (int n = 0; n <= g + 16; n++) begin
        if (n < RC) e = 0;
        else if (n == RC) e = 1;
        else if (n <= g + 2) e = 2;
        else if (n == g + 3) e = 1;
        else if (n <= g + 3 + SC) e = 2;
        else e = 3;
        n_cmp++;
        if ({state, pll_rst, sys_reset, ready, fail} !== {3'(e), outs_of(e)}) begin
          n_err++;
          $display("FAIL glitch g=%0d cyc=%0d got st=%0d outs=%b exp st=%0d outs=%b",
                   g, n, state, {pll_rst, sys_reset, ready, fail}, e, outs_of(e));
        end
        locked = (n == g) ? 1'b0 : 1'b1;
        step();
      end
    end
  endtask

  task automatic test_lock_loss();
    int losses;
    int e;
    int el;
    do_reset(1'b1);
    repeat (RUN_AT) step();
    losses = 0;
    for (int it = 0; it < 300; it++) begin
      repeat ($urandom_range(3, 0)) step();
      for (int j = 0; j <= 16; j++) begin
        if (j < 3) e = 3;
        else if (j < 3 + RC) e = 0;
        else if (j == 3 + RC) e = 1;
        else if (j <= 3 + RC + SC) e = 2;
        else e = 3;
        el = (j < 3) ? losses : ((losses + 1 > 255) ? 255 : losses + 1);
        n_cmp++;
        if ({state, pll_rst, sys_reset, ready, fail, loss_count} !== {3'(e), outs_of(e), 8'(el)}) begin
          n_err++;
          $display("FAIL lock_loss it=%0d j=%0d got st=%0d outs=%b loss=%0d exp st=%0d outs=%b loss=%0d",
                   it, j, state, {pll_rst, sys_reset, ready, fail}, loss_count, e, outs_of(e), el);
        end
        locked = (j == 0) ? 1'b0 : 1'b1;
        step();
      end
      losses = (losses + 1 > 255) ? 255 : losses + 1;
    end
  endtask

  task automatic test_relock_run();
    int k;
    int e;
    for (int it = 0; it < 3; it++) begin
      k = (it == 0) ? 1 : int'($urandom_range(5, 1));
      for (int j = 0; j <= k + 13; j++) begin
        if (j == 0) e = 3;
        else if (j <= k + 3) e = 0;
        else if (j == k + 4) e = 1;
        else if (j <= k + 12) e = 2;
        else e = 3;
        n_cmp++;
        if ({state, pll_rst, sys_reset, ready, fail, loss_count} !== {3'(e), outs_of(e), 8'd255}) begin
          n_err++;
          $display("FAIL relock_run k=%0d j=%0d got st=%0d outs=%b loss=%0d exp st=%0d outs=%b loss=255",
                   k, j, state, {pll_rst, sys_reset, ready, fail}, loss_count, e, outs_of(e));
        end
        relock_req = (j < k) ? 1'b1 : 1'b0;
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    locked = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (state !== 3'd1) begin
      n_err++;
      $display("FAIL reset_mid_pre got st=%0d exp st=1", state);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if ({state, pll_rst, sys_reset, ready, fail, loss_count} !== {3'd0, 4'b1100, 8'd0}) begin
      n_err++;
      $display("FAIL reset_mid got st=%0d outs=%b loss=%0d exp st=0 outs=1100 loss=0",
               state, {pll_rst, sys_reset, ready, fail}, loss_count);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_never_lock();
    test_lock_arrival();
    test_glitch();
    test_lock_loss();
    test_relock_run();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences bring-up and recovery of the board PLL (EHXPLLL-style primitive with `RST` input and `LOCK` output). It pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing the design reset. It also restarts the PLL on lock loss or on software request. It sits between the PLL instance and the top-level reset distribution, clocked by the free-running PLL reference clock (25 MHz), never by a PLL output.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry; about 2.6 ms at 25 MHz.
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, 8: consecutive lock timeouts before FAIL (≥1).

Ports:
- `clock`  in  1  PLL reference clock (25 MHz).
- `reset`  in  1  synchronous, active-high.
- `locked`  in  1  PLL `LOCK`, asynchronous to `clock`.
- `relock_req`  in  1  level-sampled request to restart the PLL.
- `pll_rst`  out  1  drives PLL `RST`.
- `sys_reset`  out  1  active-high reset for the rest of the design.
- `ready`  out  1  high only in RUN.
- `fail`  out  1  high only in FAIL.
- `state`  out  3  encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
- `loss_count`  out  8  number of lock losses in RUN; saturates at 255.

## Operation
- `locked` passes through a 2-FF synchronizer to produce `locked_s`. Both FFs reset to 0.
- One counter `cnt` serves all states. Its width is wide enough for max(`RST_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`). It is cleared on every state entry.
- A retry counter `retries` has width clog2(`MAX_RETRIES`+1).
- **RESET_PLL**
  - `cnt` increments each cycle.
  - When `cnt` == `RST_CYCLES`-1, go to WAIT_LOCK.
- **WAIT_LOCK**
  - If `locked_s`=1, go to STABILIZE.
  - Otherwise, when `cnt` == `LOCK_TIMEOUT`-1, increment `retries`. If the new value equals `MAX_RETRIES`, go to FAIL; else go to RESET_PLL.
- **STABILIZE**
  - If `locked_s`=0, go to WAIT_LOCK. The timeout restarts and `retries` is unchanged.
  - Otherwise, when `cnt` == `STABLE_CYCLES`-1, go to RUN and clear `retries`.
- **RUN**
  - If `locked_s`=0, go to RESET_PLL and increment `loss_count` (saturating at 255).
- **FAIL**
  - Terminal state. Exit only via `reset` or `relock_req`.
- `relock_req`=1 has priority over every other transition in every state:
  - Next state is RESET_PLL, `cnt` cleared, `retries` cleared.
  - `loss_count` is not incremented.
  - If held high, RESET_PLL restarts every cycle and `pll_rst` stays high.
- Output decode, taken from the state register so all outputs are registered:
  - `pll_rst` = RESET_PLL or FAIL.
  - `sys_reset` = not RUN.
  - `ready` = RUN.
  - `fail` = FAIL.
- `loss_count` is cleared only by `reset`.

## Timing
- While `reset`=1 and in the cycle after it drops:
  - state = RESET_PLL, `cnt`=0, `retries`=0, `loss_count`=0.
  - `pll_rst`=1, `sys_reset`=1, `ready`=0, `fail`=0, `state`=0.
- An edge on `locked` is visible to the FSM 2 cycles later.
- Worst-case latency from `locked` falling in RUN to `sys_reset`=1 is 3 cycles: 2 for the synchronizer, 1 for the state register.
- Minimum bring-up, with `locked` high throughout: `RST_CYCLES` + 1 + `STABLE_CYCLES` cycles from reset release to `ready`=1.
- `pll_rst` pulse width is exactly `RST_CYCLES` cycles per attempt, absent `relock_req`.
- If `locked` drops in the same cycle that STABILIZE's `cnt` reaches terminal, `locked_s`=0 wins: go to WAIT_LOCK, not RUN.
- If the timeout and `locked_s`=1 coincide in WAIT_LOCK, lock wins: go to STABILIZE.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `MAX_RETRIES`=3. Cycle 0 is the first cycle after reset release.

- **Clean bring-up.** `locked`=1 from cycle 0 -> `pll_rst`=1 for cycles 0–3; WAIT_LOCK at cycle 4; STABILIZE for cycles 5–12; `ready`=1 and `sys_reset`=0 from cycle 13.
- **Never locks.** `locked`=0 -> three RESET_PLL(4)+WAIT_LOCK(32) rounds, then `fail`=1 and `pll_rst`=1 from cycle 108. State stays 4 for ≥200 cycles. A 1-cycle `relock_req` then returns to state 0 and clears `fail`.
- **Glitch during STABILIZE.** `locked` low for 1 cycle in the middle of STABILIZE -> state returns to WAIT_LOCK, then STABILIZE restarts with a full 8-cycle count; `ready` rises 8 cycles after re-entry; `retries` is unaffected.
- **Lock loss in RUN.** From RUN, drop `locked` -> `sys_reset`=1 within 3 cycles and `pll_rst` pulses 4 cycles; `loss_count`=1. Repeat 300 times -> `loss_count`=255 (saturated).
- **relock_req in RUN, and reset mid-operation.**
  - `relock_req` for 1 cycle in RUN -> next cycle state=0 and `pll_rst`=1; `loss_count` unchanged.
  - `reset` asserted during WAIT_LOCK -> all outputs return to their reset values on the next cycle.
